wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back end of the execute interface: captures the execute stage's ALU result and final register write enable into an EX/WB pipeline register. It commits that result into a 32-entry general register file and serves the two operand read ports that feed execute (rdata1/rdata2), with same-cycle write-through bypass. It also keeps a retired-instruction counter for debug and performance.

Parameters:
DATA_W, 32, register and ALU data width
ADDR_W, 5, register address width (2^ADDR_W registers)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold EX/WB register contents; no new capture
flush  in  1  capture a bubble instead of the execute result
ex_valid  in  1  execute stage holds a real instruction this cycle
ex_alu_out  in  DATA_W  execute result (alu_out)
ex_wen  in  1  final register write enable from execute (rf_nwef, conditional-move already resolved)
ex_waddr  in  ADDR_W  destination register index
raddr1  in  ADDR_W  read port 1 address (rs)
raddr2  in  ADDR_W  read port 2 address (rt)
rdata1  out  DATA_W  read port 1 data
rdata2  out  DATA_W  read port 2 data
wb_valid  out  1  EX/WB register holds a real instruction
wb_wen  out  1  WB-stage write enable (for hazard/forwarding logic)
wb_waddr  out  ADDR_W  WB-stage destination
wb_wdata  out  DATA_W  WB-stage data
retire_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- EX/WB register fields: valid, wen, waddr, wdata. Update priority at each edge:
  - rst: all fields 0.
  - flush: valid=0, wen=0; waddr/wdata cleared to 0.
  - stall: hold all fields.
  - otherwise: valid<=ex_valid, wen<=ex_valid&ex_wen, waddr<=ex_waddr, wdata<=ex_alu_out.
- wb_* outputs are direct register outputs; all read 0 after reset. Latency is 1 cycle from execute to WB stage.
- Register file write:
  - At each edge where !rst and wb_valid and wb_wen and wb_waddr!=0, regs[wb_waddr]<=wb_wdata.
  - The write happens regardless of stall or flush; the current WB entry always commits. A repeated write while stalled is idempotent.
- Register 0: always reads 0. Writes to index 0 are dropped. wb_wen may still be 1 for index 0; forwarding logic must check the address.
- Reset: synchronous clear of all 2^ADDR_W registers to 0. Any pending WB write at a reset edge is discarded, because reset has priority.
- Reads: combinational.
  - rdataN = 0 if raddrN==0.
  - else wb_wdata if wb_valid&wb_wen&(wb_waddr==raddrN) (write-through bypass).
  - else regs[raddrN].
  - Both ports are independent; the same address on both ports returns identical data.
- Retire counter:
  - Increments by 1 at each edge where !rst and wb_valid and (!stall or flush), i.e. the WB entry leaves the stage.
  - Entries with wen=0 (e.g. conditional move not taken, stores, branches) still count.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared by rst.
- Simultaneous events: rst overrides flush and stall; flush overrides stall. ex_* inputs are ignored when stall or flush is asserted.
- No combinational path from ex_* to rdata*. Forwarding from the execute stage itself is outside this block.

Test Plan:
- Reset: preload several registers, assert rst 1 cycle -> every register reads 0, wb_valid=0, retire_cnt=0, and a WB write pending at the reset edge is not committed.
- Basic write/read: ex_valid=1, ex_wen=1, ex_waddr=5, ex_alu_out=0xDEADBEEF -> next cycle wb_waddr=5, and raddr1=5 returns 0xDEADBEEF via bypass. The cycle after that, it returns the same value from the array; retire_cnt=1.
- Conditional move not taken: ex_wen=0, ex_waddr=7, ex_alu_out=0x1234 with r7=0xAAAA -> r7 stays 0xAAAA, and rdata2 on raddr2=7 never shows 0x1234; retire_cnt still increments.
- Register zero: write 0xFFFFFFFF to index 0 -> rdata1/rdata2 on address 0 read 0 in every cycle, including the bypass cycle.
- Stall and flush:
  - Stall 3 cycles with new ex_* values applied -> wb_* unchanged and retire_cnt unchanged.
  - Then flush with stall still high -> wb_valid=0 next cycle, retire_cnt+1, and the original entry is committed exactly once in value.
- Counter wrap: force retire_cnt to 0xFFFFFFFF (CNT_W=32), retire one instruction -> retire_cnt=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the execute stage and the write-back / register-file
// block: pipeline control, execute result, operand read ports and the
// write-back stage view used by hazard/forwarding logic.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  // Pipeline control
  logic              stall;
  logic              flush;

  // Execute-stage result
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_out;
  logic              ex_wen;
  logic [ADDR_W-1:0] ex_waddr;

  // Operand read ports
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // Write-back stage view
  logic              wb_valid;
  logic              wb_wen;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic [CNT_W-1:0]  retire_cnt;

  // Execute side drives the pipeline and consumes read data
  modport master (
    output stall, flush,
    output ex_valid, ex_alu_out, ex_wen, ex_waddr,
    output raddr1, raddr2,
    input  rdata1, rdata2,
    input  wb_valid, wb_wen, wb_waddr, wb_wdata, retire_cnt
  );

  // Register-file block side
  modport slave (
    input  stall, flush,
    input  ex_valid, ex_alu_out, ex_wen, ex_waddr,
    input  raddr1, raddr2,
    output rdata1, rdata2,
    output wb_valid, wb_wen, wb_waddr, wb_wdata, retire_cnt
  );

endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and general register file.
// Captures the execute result into the EX/WB register, commits it into a
// 2^ADDR_W entry register file (entry 0 hard-wired to zero), serves two
// combinational read ports with write-through bypass from the WB stage and
// counts retired instructions.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);

  localparam int NREGS = 1 << ADDR_W;

  // EX/WB pipeline register
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q,   wb_wen_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

  // Register array and retire counter
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  retire_q, retire_d;

  // Decoded control
  logic              commit_s;
  logic              leave_s;
  logic [DATA_W-1:0] arr1_s;
  logic [DATA_W-1:0] arr2_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  // Read-port resolution: zero register, then WB bypass, then array contents.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              byp_valid,
    input logic              byp_wen,
    input logic [ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    logic [DATA_W-1:0] res;
    if (addr == {ADDR_W{1'b0}}) begin
      res = {DATA_W{1'b0}};
    end else if (byp_valid && byp_wen && (byp_addr == addr)) begin
      res = byp_data;
    end else begin
      res = arr_val;
    end
    return res;
  endfunction

  // EX/WB next state: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_wen_d   = wb_wen_q;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    if (bus.flush) begin
      wb_valid_d = 1'b0;
      wb_wen_d   = 1'b0;
      wb_waddr_d = {ADDR_W{1'b0}};
      wb_wdata_d = {DATA_W{1'b0}};
    end else if (bus.stall) begin
      wb_valid_d = wb_valid_q;
      wb_wen_d   = wb_wen_q;
      wb_waddr_d = wb_waddr_q;
      wb_wdata_d = wb_wdata_q;
    end else begin
      wb_valid_d = bus.ex_valid;
      wb_wen_d   = bus.ex_valid & bus.ex_wen;
      wb_waddr_d = bus.ex_waddr;
      wb_wdata_d = bus.ex_alu_out;
    end
  end

  // EX/WB register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= {ADDR_W{1'b0}};
      wb_wdata_q <= {DATA_W{1'b0}};
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  // Commit and retire decode; the WB entry commits even while stalled,
  // which is harmless because the repeated write carries the same value.
  always_comb begin
    commit_s = wb_valid_q & wb_wen_q & (wb_waddr_q != {ADDR_W{1'b0}});
    leave_s  = wb_valid_q & (~bus.stall | bus.flush);
  end

  // Register array: clear on reset (pending write dropped), else commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (commit_s) begin
      regs_q[wb_waddr_q] <= wb_wdata_q;
    end else begin
      regs_q[wb_waddr_q] <= regs_q[wb_waddr_q];
    end
  end

  // Retire counter next state; wraps naturally at 2^CNT_W.
  always_comb begin
    retire_d = retire_q;
    if (leave_s) begin
      retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_d = retire_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= {CNT_W{1'b0}};
    end else begin
      retire_q <= retire_d;
    end
  end

  // Operand reads; only WB-stage state feeds the bypass, never ex_*.
  always_comb begin
    arr1_s   = regs_q[bus.raddr1];
    arr2_s   = regs_q[bus.raddr2];
    rdata1_s = read_port(bus.raddr1, arr1_s, wb_valid_q, wb_wen_q,
                         wb_waddr_q, wb_wdata_q);
    rdata2_s = read_port(bus.raddr2, arr2_s, wb_valid_q, wb_wen_q,
                         wb_waddr_q, wb_wdata_q);
  end

  assign bus.rdata1     = rdata1_s;
  assign bus.rdata2     = rdata2_s;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_wen     = wb_wen_q;
  assign bus.wb_waddr   = wb_waddr_q;
  assign bus.wb_wdata   = wb_wdata_q;
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. A second instance with a
// 4-bit retire counter exercises counter wrap-around in a few cycles.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    bus.ex_valid   = v;
    bus.ex_wen     = w;
    bus.ex_waddr   = a;
    bus.ex_alu_out = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;  bus.flush = 1'b0;
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus4.stall = 1'b0; bus4.flush = 1'b0;
    bus4.raddr1 = 5'd0; bus4.raddr2 = 5'd0;
    bus4.ex_valid = 1'b0; bus4.ex_wen = 1'b0;
    bus4.ex_waddr = 5'd0; bus4.ex_alu_out = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_wen",   {31'd0, bus.wb_wen},   32'd0);
    chk("rst_wb_waddr", {27'd0, bus.wb_waddr}, 32'd0);
    chk("rst_wb_wdata", bus.wb_wdata,          32'd0);
    chk("rst_retire",   bus.retire_cnt,        32'd0);

    // Basic write: bypass cycle then array cycle
    ex_drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    bus.raddr1 = 5'd5;
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("basic_wb_waddr", {27'd0, bus.wb_waddr}, 32'd5);
    chk("basic_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("basic_bypass",   bus.rdata1,            32'hDEADBEEF);
    chk("basic_retire0",  bus.retire_cnt,        32'd0);
    tick();
    chk("basic_array",    bus.rdata1,            32'hDEADBEEF);
    chk("basic_wb_idle",  {31'd0, bus.wb_valid}, 32'd0);
    chk("basic_retire1",  bus.retire_cnt,        32'd1);
    bus.raddr2 = 5'd5;
    #1;
    chk("same_addr_p1",   bus.rdata1,            32'hDEADBEEF);
    chk("same_addr_p2",   bus.rdata2,            32'hDEADBEEF);

    // Conditional move not taken
    ex_drive(1'b1, 1'b1, 5'd7, 32'h0000AAAA);
    tick();
    ex_drive(1'b1, 1'b0, 5'd7, 32'h00001234);
    bus.raddr2 = 5'd7;
    tick();
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("cmov_wb_wen",    {31'd0, bus.wb_wen},   32'd0);
    chk("cmov_wb_valid",  {31'd0, bus.wb_valid}, 32'd1);
    chk("cmov_rd_wb",     bus.rdata2,            32'h0000AAAA);
    tick();
    chk("cmov_rd_after",  bus.rdata2,            32'h0000AAAA);
    chk("cmov_retire",    bus.retire_cnt,        32'd3);

    // Register zero
    ex_drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    tick();
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("r0_wb_wen",      {31'd0, bus.wb_wen},   32'd1);
    chk("r0_bypass_p1",   bus.rdata1,            32'd0);
    chk("r0_bypass_p2",   bus.rdata2,            32'd0);
    tick();
    chk("r0_after_p1",    bus.rdata1,            32'd0);
    chk("r0_after_p2",    bus.rdata2,            32'd0);
    chk("r0_retire",      bus.retire_cnt,        32'd4);

    // Stall with changing ex_* inputs, then flush while stalled
    ex_drive(1'b1, 1'b1, 5'd9, 32'h12345678);
    tick();
    bus.stall = 1'b1;
    ex_drive(1'b1, 1'b1, 5'd10, 32'hBAD0BAD0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.ex_alu_out = bus.ex_alu_out + 32'd1;
      chk("stall_wb_waddr", {27'd0, bus.wb_waddr}, 32'd9);
      chk("stall_wb_wdata", bus.wb_wdata,          32'h12345678);
      chk("stall_retire",   bus.retire_cnt,        32'd4);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus.raddr1 = 5'd9; bus.raddr2 = 5'd10;
    #1;
    chk("flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("flush_wb_waddr", {27'd0, bus.wb_waddr}, 32'd0);
    chk("flush_retire",   bus.retire_cnt,        32'd5);
    chk("flush_commit",   bus.rdata1,            32'h12345678);
    chk("flush_no_r10",   bus.rdata2,            32'd0);
    tick();
    chk("flush_retire_h", bus.retire_cnt,        32'd5);

    // Reset with a pending WB write to r12
    ex_drive(1'b1, 1'b1, 5'd12, 32'h00005555);
    tick();
    ex_drive(1'b0, 1'b0, 5'd0, 32'h0);
    bus.raddr1 = 5'd7;
    #1;
    chk("pre_rst_r7",     bus.rdata1,            32'h0000AAAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_wb_valid",  {31'd0, bus.wb_valid}, 32'd0);
    chk("rst2_retire",    bus.retire_cnt,        32'd0);
    for (int a = 1; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      #1;
      chk("rst2_reg", bus.rdata1, 32'd0);
    end

    // Counter wrap on the 4-bit instance: 15 retirements then one more
    bus4.ex_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
    end
    chk("wrap_max",  {28'd0, bus4.retire_cnt}, 32'd15);
    tick();
    chk("wrap_zero", {28'd0, bus4.retire_cnt}, 32'd0);
    bus4.ex_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
